// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder result stream, the frame accumulator and
// the consumer of frame totals.
interface sum_accumulator_if #(
  parameter int NUM_BITS    = 4,
  parameter int NUM_SAMPLES = 8
);
  localparam int CNT_BITS = $clog2(NUM_SAMPLES);
  localparam int ACC_BITS = NUM_BITS + 1 + CNT_BITS;

  logic [NUM_BITS-1:0] in_sum;
  logic                in_overflow;
  logic                in_valid;
  logic                in_ready;
  logic                clear;
  logic [ACC_BITS-1:0] result;
  logic                result_valid;
  logic                result_ack;
  logic [CNT_BITS-1:0] sample_count;

  modport master (
    output in_sum, in_overflow, in_valid, clear, result_ack,
    input  in_ready, result, result_valid, sample_count
  );

  modport slave (
    input  in_sum, in_overflow, in_valid, clear, result_ack,
    output in_ready, result, result_valid, sample_count
  );
endinterface

// File: rtl/sum_accumulator.sv
// Adds NUM_SAMPLES {overflow, sum} adder results into a frame total and holds
// that total on a valid/ack handshake until the consumer takes it.
module sum_accumulator #(
  parameter int NUM_BITS    = 4,
  parameter int NUM_SAMPLES = 8
) (
  input logic               clk,
  input logic               rst,
  sum_accumulator_if.slave  bus
);
  localparam int CNT_BITS = $clog2(NUM_SAMPLES);
  localparam int ACC_BITS = NUM_BITS + 1 + CNT_BITS;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [ACC_BITS-1:0] result_q, result_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic                in_ready;
  logic                accept;
  logic                last_sample;
  logic [ACC_BITS-1:0] sample;

  assign sample      = {{CNT_BITS{1'b0}}, bus.in_overflow, bus.in_sum};
  assign accept      = bus.in_valid && in_ready && !bus.clear;
  assign last_sample = (cnt_q == LAST_CNT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every other condition
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = ACCUM;
        ACCUM:   if (accept && last_sample) state_d = DONE;
        DONE:    if (bus.result_ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs: no combinational path from any input
  always_comb begin
    in_ready         = (state_q != DONE);
    bus.in_ready     = in_ready;
    bus.result_valid = (state_q == DONE);
  end

  // Datapath next state; acc is already zero in IDLE so one adder covers both cases
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (bus.clear) begin
      acc_d    = '0;
      cnt_d    = '0;
      result_d = '0;
    end else if (accept) begin
      if (last_sample) begin
        result_d = acc_q + sample;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = acc_q + sample;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.sample_count = cnt_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: frames with hand-computed totals, reset,
// clear, back-pressure and overflow weighting.
module tb_sum_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sum_accumulator_if #(.NUM_BITS(4), .NUM_SAMPLES(8)) bus ();

  sum_accumulator #(.NUM_BITS(4), .NUM_SAMPLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // One sample presented for one clock; caller sees outputs 1ns after the edge
  task automatic push(input logic ovf, input logic [3:0] s);
    bus.in_valid    = 1'b1;
    bus.in_overflow = ovf;
    bus.in_sum      = s;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic ack_result();
    bus.result_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ack = 1'b0;
    check("ack_ready", 32'(bus.in_ready), 32'd1);
    check("ack_valid", 32'(bus.result_valid), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic ovf, input logic [3:0] s,
                           input logic [31:0] exp);
    for (int i = 0; i < 8; i++) push(ovf, s);
    check({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
    check({tag, "_result"}, 32'(bus.result), exp);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_count"}, 32'(bus.sample_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_overflow = 1'b0;
    bus.in_sum      = 4'd0;
    bus.clear       = 1'b0;
    bus.result_ack  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_count", 32'(bus.sample_count), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-frame, asserted between edges
    for (int i = 0; i < 3; i++) push(1'b0, 4'd5);
    check("mid_count", 32'(bus.sample_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(bus.sample_count), 32'd0);
    check("mid_rst_valid", 32'(bus.result_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_frame("ones", 1'b0, 4'd1, 32'd8);
    ack_result();
    check("ack_keeps_result", 32'(bus.result), 32'd8);

    // Maximum values back-to-back, held without ack
    run_frame("max", 1'b1, 4'hF, 32'd248);
    @(posedge clk);
    #1;
    check("max_hold_ready", 32'(bus.in_ready), 32'd0);
    ack_result();

    // Gapped input 1..8
    for (int i = 1; i <= 8; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      push(1'b0, 4'(i));
      check("gap_count", 32'(bus.sample_count), 32'(i % 8));
    end
    check("gap_valid", 32'(bus.result_valid), 32'd1);
    check("gap_result", 32'(bus.result), 32'd36);

    // Ack held off while upstream keeps offering 9
    bus.in_valid = 1'b1;
    bus.in_sum   = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_result", 32'(bus.result), 32'd36);
      check("hold_count", 32'(bus.sample_count), 32'd0);
    end
    bus.in_valid = 1'b0;
    ack_result();
    check("hold_after_count", 32'(bus.sample_count), 32'd0);
    run_frame("twos", 1'b0, 4'd2, 32'd16);
    ack_result();

    // Clear together with a valid sample
    for (int i = 0; i < 3; i++) push(1'b0, 4'd4);
    bus.clear = 1'b1;
    push(1'b0, 4'd7);
    bus.clear = 1'b0;
    check("clr_count", 32'(bus.sample_count), 32'd0);
    check("clr_ready", 32'(bus.in_ready), 32'd1);
    run_frame("threes", 1'b0, 4'd3, 32'd24);

    // Clear in DONE
    bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    check("clr_done_valid", 32'(bus.result_valid), 32'd0);
    check("clr_done_result", 32'(bus.result), 32'd0);
    check("clr_done_ready", 32'(bus.in_ready), 32'd1);

    // Ack outside DONE is ignored
    bus.result_ack = 1'b1;
    push(1'b0, 4'd6);
    bus.result_ack = 1'b0;
    check("stray_ack_count", 32'(bus.sample_count), 32'd1);
    bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;

    // Overflow bit carries weight 16
    run_frame("ovf", 1'b1, 4'd0, 32'd128);

    // Reset while a result is pending
    #2 rst = 1'b1;
    #1;
    check("done_rst_valid", 32'(bus.result_valid), 32'd0);
    check("done_rst_result", 32'(bus.result), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Sequential accumulator that sits directly downstream of the n-bit adder and consumes its `{overflow, sum}` result stream. It adds a fixed-length frame of `NUM_SAMPLES` adder results into a wide accumulator and presents the frame total on a valid/ack handshake. Input flow control uses a valid/ready handshake. The block holds each completed result until the consumer acknowledges it.

## Interface
- `NUM_BITS`, default 4: width of the adder's sum field.
- `NUM_SAMPLES`, default 8: samples per frame; must be a power of two, ≥ 2.
- `CNT_BITS`, derived: `$clog2(NUM_SAMPLES)`; 3 at the defaults.
- `ACC_BITS`, derived: `NUM_BITS + 1 + CNT_BITS`; 8 at the defaults.

Clocking and reset: one clock; reset is asynchronous and active-high.

- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `in_sum`  in  NUM_BITS  — sum output of the upstream adder.
- `in_overflow`  in  1  — carry-out of the upstream adder; it has weight 2^NUM_BITS.
- `in_valid`  in  1  — `in_sum` and `in_overflow` are valid this cycle.
- `in_ready`  out  1  — block accepts a sample this cycle.
- `clear`  in  1  — synchronous abort: discards the partial frame and any pending result.
- `result`  out  ACC_BITS  — frame total.
- `result_valid`  out  1  — `result` holds a completed frame.
- `result_ack`  in  1  — consumer takes the result.
- `sample_count`  out  CNT_BITS  — number of samples accepted in the current frame.

## Operation
- **Sample value.** Each sample is `{in_overflow, in_sum}`, zero-extended to `ACC_BITS`.
- **No overflow.** `ACC_BITS` is sized so that `NUM_SAMPLES` maximum samples cannot overflow. No saturation or wrap is needed.
- **Accept.** A sample is accepted when `in_valid && in_ready && !clear` at a rising edge.
- **States:**
  - IDLE: `acc = 0`, `sample_count = 0`, `in_ready = 1`.
  - ACCUM: a partial frame is in progress; `in_ready = 1`.
  - DONE: the result is held; `in_ready = 0`.
- **`in_ready` decode.** `in_ready` is a pure decode of state (Moore): `state != DONE`. It has no combinational path from any input.
- **Transitions:**
  - IDLE → ACCUM: on an accept, unless it is also the final sample (not possible since `NUM_SAMPLES` ≥ 2). `acc <= sample`, `sample_count <= 1`.
  - ACCUM → ACCUM: on an accept with `sample_count < NUM_SAMPLES-1`. `acc <= acc + sample`, `sample_count++`.
  - ACCUM → DONE: on an accept with `sample_count == NUM_SAMPLES-1`. `result <= acc + sample`, `result_valid <= 1`, `acc <= 0`, `sample_count <= 0`.
  - DONE → IDLE: on `result_ack`. `result_valid <= 0`; `result` keeps its value.
- **Idle cycles.** Cycles with `in_valid = 0` change nothing.
- **`clear`.** Highest priority after `rst`, in any state. Next state is IDLE. `acc`, `sample_count` and `result` go to 0, and `result_valid` goes to 0. A sample presented in the same cycle as `clear` is dropped.
- **`result_ack` outside DONE.** Ignored.
- **`in_valid` in DONE.** Ignored; no sample is accepted.

## Timing
- **Reset values.** While `rst` is high, and immediately on its assertion without waiting for a clock: state = IDLE, `result = 0`, `result_valid = 0`, `sample_count = 0`, `in_ready = 1`.
- **Reset mid-frame.** A reset in ACCUM or DONE discards the partial frame and any pending result.
- **Result latency.** `result_valid` and the new `result` are visible in the cycle after the edge that accepts the final sample.
- **Back-to-back frames.**
  - If `result_ack` is high in the first DONE cycle, `in_ready` returns to 1 in the following cycle.
  - Minimum frame period is `NUM_SAMPLES + 1` cycles.
- **Result stability.** `result` is stable for the entire time `result_valid = 1`.
- **Count wrap.** `sample_count` wraps `NUM_SAMPLES-1 → 0` on the final accept. Its value in DONE is 0.

## Test plan
- **Reset mid-frame.** Accept 3 samples of 5, then pulse `rst` between clock edges. Required: `result = 0`, `result_valid = 0`, `sample_count = 0`, `in_ready = 1` immediately. The next 8 samples of 1 give `result = 8`.
- **Maximum values.** Stream 8 samples of `{1, 4'hF}` (31) back-to-back. Required: `result = 8'hF8` (248) and `result_valid = 1` one cycle after the 8th accept; `in_ready = 0` until ack.
- **Gapped input.** Send samples 1..8 with `in_overflow = 0` and random `in_valid` gaps. Required: `result = 36`; `sample_count` steps 1..7 then 0.
- **Ack held off.** Complete a frame, then hold `result_ack = 0` for 5 cycles with `in_valid = 1` and `in_sum = 9`. Required: `result` is unchanged and no sample is accepted. Then ack. Required: IDLE next cycle, and the next frame of 8 × 2 gives `result = 16`.
- **Clear with valid.** After 3 accepts, assert `clear` together with `in_valid`. Required: that sample is dropped and `sample_count = 0`. The next 8 samples of 3 give `result = 24`. Also assert `clear` in DONE. Required: `result_valid = 0` and `result = 0` next cycle.
- **Overflow weighting.** Send 8 samples with `in_overflow = 1` and `in_sum = 0`. Required: `result = 128`.
